// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the slot scanner.
package scan_pkg;

  localparam int SLOTS = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    BLANK
  } scan_state_t;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller (master) and the scanner (slave).
// frame_done exists only when SCAN_SEQUENCER_FRAME_PULSE_EN is defined.
interface scan_sequencer_if;
  import scan_pkg::*;

  logic             run;
  logic [SLOTS-1:0] mask;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             busy;
`ifdef SCAN_SEQUENCER_FRAME_PULSE_EN
  logic             frame_done;

  modport master (
    output run,
    output mask,
    input  sel,
    input  en,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  run,
    input  mask,
    output sel,
    output en,
    output busy,
    output frame_done
  );
`else
  modport master (
    output run,
    output mask,
    input  sel,
    input  en,
    input  busy
  );

  modport slave (
    input  run,
    input  mask,
    output sel,
    output en,
    output busy
  );
`endif

endinterface

// File: rtl/scan_sequencer_next_idx.sv
// Wrap-around priority search: first set mask bit strictly above cur, wrapping 3 -> 0,
// landing on cur itself only when it is the sole set bit.
module scan_next_idx
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0] cur,
  input  logic [SLOTS-1:0] mask,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic             none
);

  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    nxt  = cur;
    idx  = cur;
    none = (mask == '0);
    for (int k = SLOTS; k >= 1; k--) begin
      idx = cur + SEL_W'(k);
      if (mask[idx]) begin
        nxt = idx;
      end
    end
    wrap = !none && (nxt <= cur);
  end

endmodule

// File: rtl/scan_sequencer.sv
// Four-slot scanner producing registered sel/en for a 2-to-4 decoder with dwell and blanking.
// Optional frame_done pulse is built only when SCAN_SEQUENCER_FRAME_PULSE_EN is defined.
module scan_sequencer #(
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input logic             clk,
  input logic             rst_n,
  scan_sequencer_if.slave bus
);
  import scan_pkg::SEL_W;
  import scan_pkg::scan_state_t;

  localparam int DWELL_W = $clog2(DWELL + 1);
  localparam int BLANK_W = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK > 0) ? BLANK - 1 : 0);

  scan_state_t        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [SEL_W-1:0]   pend_q, pend_d;

  logic [SEL_W-1:0]   search_cur;
  logic [SEL_W-1:0]   nxt_idx;
  logic               nxt_none;
`ifdef SCAN_SEQUENCER_FRAME_PULSE_EN
  logic               nxt_wrap;
  logic               frame_q, frame_d;
  logic               pend_wrap_q, pend_wrap_d;
`else
  logic               nxt_wrap_unused;
`endif

  // From IDLE the search starts "above slot 3" so slot 0 is considered first.
  assign search_cur = (state_q == scan_pkg::IDLE) ? {SEL_W{1'b1}} : sel_q;

  scan_next_idx u_next_idx (
    .cur  (search_cur),
    .mask (bus.mask),
    .nxt  (nxt_idx),
`ifdef SCAN_SEQUENCER_FRAME_PULSE_EN
    .wrap (nxt_wrap),
`else
    .wrap (nxt_wrap_unused),
`endif
    .none (nxt_none)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= scan_pkg::IDLE;
      sel_q       <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      dwell_q     <= '0;
      blank_q     <= '0;
      pend_q      <= '0;
`ifdef SCAN_SEQUENCER_FRAME_PULSE_EN
      frame_q     <= 1'b0;
      pend_wrap_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      dwell_q     <= dwell_d;
      blank_q     <= blank_d;
      pend_q      <= pend_d;
`ifdef SCAN_SEQUENCER_FRAME_PULSE_EN
      frame_q     <= frame_d;
      pend_wrap_q <= pend_wrap_d;
`endif
    end
  end

  // The next slot is chosen at the end of dwell; with blanking it is parked in pend_q
  // until the gap ends. run = 0 overrides any boundary.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    en_d        = en_q;
    busy_d      = busy_q;
    dwell_d     = dwell_q;
    blank_d     = blank_q;
    pend_d      = pend_q;
`ifdef SCAN_SEQUENCER_FRAME_PULSE_EN
    frame_d     = 1'b0;
    pend_wrap_d = pend_wrap_q;
`endif
    case (state_q)
      scan_pkg::IDLE: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        dwell_d = '0;
        blank_d = '0;
        if (bus.run && !nxt_none) begin
          state_d = scan_pkg::ACTIVE;
          sel_d   = nxt_idx;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      scan_pkg::ACTIVE: begin
        if (!bus.run || ((dwell_q == DWELL_LAST) && nxt_none)) begin
          state_d = scan_pkg::IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          dwell_d = '0;
          blank_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          blank_d = '0;
          if (BLANK > 0) begin
            state_d = scan_pkg::BLANK;
            en_d    = 1'b0;
            pend_d  = nxt_idx;
`ifdef SCAN_SEQUENCER_FRAME_PULSE_EN
            pend_wrap_d = nxt_wrap;
`endif
          end else begin
            sel_d = nxt_idx;
            en_d  = 1'b1;
`ifdef SCAN_SEQUENCER_FRAME_PULSE_EN
            frame_d = nxt_wrap;
`endif
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      scan_pkg::BLANK: begin
        if (!bus.run) begin
          state_d = scan_pkg::IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          dwell_d = '0;
          blank_d = '0;
        end else if (blank_q == BLANK_LAST) begin
          state_d = scan_pkg::ACTIVE;
          sel_d   = pend_q;
          en_d    = 1'b1;
          dwell_d = '0;
          blank_d = '0;
`ifdef SCAN_SEQUENCER_FRAME_PULSE_EN
          frame_d = pend_wrap_q;
`endif
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      default: begin
        state_d = scan_pkg::IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.sel  = sel_q;
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
`ifdef SCAN_SEQUENCER_FRAME_PULSE_EN
  assign bus.frame_done = frame_q;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: DWELL=4 with BLANK=2 and BLANK=0 instances.
// frame_done checks are compiled when SCAN_SEQUENCER_FRAME_PULSE_EN is defined.
module tb_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  scan_sequencer_if bus ();
  scan_sequencer_if bus_nb ();

  scan_sequencer #(.DWELL(4), .BLANK(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  scan_sequencer #(.DWELL(4), .BLANK(0)) dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [3:0] m, input int n);
    bus.run  = r;
    bus.mask = m;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] es, input logic ee, input logic eb);
    checks++;
    assert (bus.sel === es) else begin
      failures++;
      $error("FAIL %s sel observed=%0d expected=%0d", tag, bus.sel, es);
    end
    checks++;
    assert (bus.en === ee) else begin
      failures++;
      $error("FAIL %s en observed=%0b expected=%0b", tag, bus.en, ee);
    end
    checks++;
    assert (bus.busy === eb) else begin
      failures++;
      $error("FAIL %s busy observed=%0b expected=%0b", tag, bus.busy, eb);
    end
  endtask

  task automatic checkNb(input string tag, input logic [1:0] es, input logic ee, input logic eb);
    checks++;
    assert (bus_nb.sel === es) else begin
      failures++;
      $error("FAIL %s sel observed=%0d expected=%0d", tag, bus_nb.sel, es);
    end
    checks++;
    assert (bus_nb.en === ee) else begin
      failures++;
      $error("FAIL %s en observed=%0b expected=%0b", tag, bus_nb.en, ee);
    end
    checks++;
    assert (bus_nb.busy === eb) else begin
      failures++;
      $error("FAIL %s busy observed=%0b expected=%0b", tag, bus_nb.busy, eb);
    end
  endtask

  // seq packs the visited slot indices two bits each, first slot in the low bits.
  task automatic checkScan(input string tag, input logic [15:0] seq, input int nslots);
    for (int k = 0; k < nslots * 6; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput($sformatf("%s k=%0d", tag, k), seq[2*(k/6) +: 2], (k % 6) < 4, 1'b1);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.run     = 1'b1;
    bus.mask    = 4'b1111;
    bus_nb.run  = 1'b0;
    bus_nb.mask = 4'b0000;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset%0d", i), 2'd0, 1'b0, 1'b0);
    end
    checkNb("nb_reset", 2'd0, 1'b0, 1'b0);

    rst_n = 1'b1;
    @(negedge clk);
    checkScan("full", {6'b0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 5);
    applyStimulus(1'b0, 4'b1111, 1);
    checkOutput("full_stop", 2'd0, 1'b0, 1'b0);

    applyStimulus(1'b1, 4'b1010, 1);
    checkScan("sparse", {8'b0, 2'd3, 2'd1, 2'd3, 2'd1}, 4);
    applyStimulus(1'b0, 4'b1010, 1);
    checkOutput("sparse_stop", 2'd3, 1'b0, 1'b0);

    applyStimulus(1'b1, 4'b0100, 1);
    checkScan("single", {10'b0, 2'd2, 2'd2, 2'd2}, 3);
    applyStimulus(1'b0, 4'b0100, 1);
    checkOutput("single_stop", 2'd2, 1'b0, 1'b0);

    applyStimulus(1'b1, 4'b1111, 1);
    checkScan("edit_pre", 16'h0000, 1);
    applyStimulus(1'b1, 4'b1111, 1);
    checkOutput("edit k=6", 2'd1, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1111, 1);
    checkOutput("edit k=7", 2'd1, 1'b1, 1'b1);
    bus.mask = 4'b0001;
    for (int k = 8; k <= 12; k++) begin
      @(negedge clk);
      checkOutput($sformatf("edit k=%0d", k), (k < 12) ? 2'd1 : 2'd0, (k < 10) || (k == 12), 1'b1);
    end
    applyStimulus(1'b1, 4'b0001, 6);
    checkOutput("edit_repeat", 2'd0, 1'b1, 1'b1);

    applyStimulus(1'b1, 4'b0000, 1);
    checkOutput("clear_finish", 2'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0000, 5);
    checkOutput("clear_idle", 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 3);
    checkOutput("clear_stay", 2'd0, 1'b0, 1'b0);

    applyStimulus(1'b1, 4'b1111, 1);
    checkOutput("stop_start", 2'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1111, 13);
    checkOutput("stop_slot2", 2'd2, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1);
    checkOutput("stop_idle", 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1111, 2);
    checkOutput("stop_hold", 2'd2, 1'b0, 1'b0);

    applyStimulus(1'b1, 4'b1100, 1);
    checkOutput("restart", 2'd2, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1100, 3);
    checkOutput("restart k=3", 2'd2, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1100, 1);
    checkOutput("restart k=4", 2'd2, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b1100, 2);
    checkOutput("restart k=6", 2'd3, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1100, 1);
    checkOutput("restart k=7", 2'd3, 1'b1, 1'b1);

    rst_n = 1'b0;
    applyStimulus(1'b1, 4'b1100, 1);
    checkOutput("midreset", 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1100, 1);
    checkOutput("midreset_hold", 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b1100, 1);
    checkOutput("midreset_release", 2'd2, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b1100, 1);

    bus_nb.mask = 4'b1111;
    bus_nb.run  = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      checkNb($sformatf("noblank k=%0d", k), 2'((k / 4) % 4), 1'b1, 1'b1);
    end
    bus_nb.run = 1'b0;
    @(negedge clk);
    checkNb("noblank_stop", 2'd0, 1'b0, 1'b0);

`ifdef SCAN_SEQUENCER_FRAME_PULSE_EN
    applyStimulus(1'b1, 4'b1011, 1);
    for (int k = 0; k < 38; k++) begin
      logic [5:0] order;
      logic [1:0] exp_sel;
      if (k > 0) @(negedge clk);
      order   = {2'd3, 2'd1, 2'd0};
      exp_sel = order[2*((k / 6) % 3) +: 2];
      checks++;
      assert (bus.frame_done === ((k == 18) || (k == 36))) else begin
        failures++;
        $error("FAIL frame k=%0d frame_done observed=%0b expected=%0b", k, bus.frame_done, (k == 18) || (k == 36));
      end
      checks++;
      assert (bus.sel === exp_sel) else begin
        failures++;
        $error("FAIL frame_sel k=%0d sel observed=%0d expected=%0d", k, bus.sel, exp_sel);
      end
    end
    applyStimulus(1'b0, 4'b1011, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
